snn_synapse_accum: RTL and testbench

- Upstream feeder stage for one LIF neuron.
- Once per SNN timestep, it takes a binary input spike vector and serially sums the Q16.16 synaptic weights of the active inputs.
- Weights come from an external synchronous weight memory.
- The result is driven as a one-cycle signed current pulse on the neuron's Spike_in. All other cycles drive zero, so the neuron integrates exactly one weighted sum per timestep.

---
 rtl/snn_synapse_accum.sv | 67 ++++++
 tb/tb_snn_synapse_accum.sv | 105 ++++++++++
 2 files changed

// File: rtl/snn_synapse_accum.sv
// snn_synapse_accum: per-timestep serial sum of active-input Q16.16 weights, emitted as a one-cycle current pulse.
// Define SYN_SATURATE_EN to clamp the sum to signed 32-bit; otherwise the low 32 bits wrap.
module snn_synapse_accum #(
  parameter int N_INPUTS = 16,
  parameter int ADDR_W   = 4,
  parameter int ACC_W    = 40
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [N_INPUTS-1:0] spike_vec,
  output logic                busy,
  output logic                weight_rd_en,
  output logic [ADDR_W-1:0]   weight_addr,
  input  logic [31:0]         weight_data,
  output logic [31:0]         current_out,
  output logic                current_valid
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_INPUTS - 1);
  state_t state, state_n;
  logic [N_INPUTS-1:0] vec;
  logic signed [ACC_W-1:0] acc, acc_n;
  logic d_en;
  logic [ADDR_W-1:0] d_idx;
  logic [31:0] sum32;
  always_comb begin
    state_n = state == IDLE  ? (start ? READ : IDLE) :
              state == READ  ? (weight_addr == LAST ? DRAIN : READ) :
              state == DRAIN ? DONE : IDLE;
  end
  // weight_data belongs to the address issued one cycle earlier
  always_comb begin
    acc_n = (d_en && vec[d_idx]) ? acc + {{(ACC_W-32){weight_data[31]}}, weight_data} : acc;
`ifdef SYN_SATURATE_EN
    sum32 = (&acc_n[ACC_W-1:31] || ~|acc_n[ACC_W-1:31]) ? acc_n[31:0] :
            acc_n[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
    sum32 = acc_n[31:0];
`endif
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      vec           <= '0;
      acc           <= '0;
      d_en          <= 1'b0;
      d_idx         <= '0;
      busy          <= 1'b0;
      weight_rd_en  <= 1'b0;
      weight_addr   <= '0;
      current_out   <= '0;
      current_valid <= 1'b0;
    end else begin
      state         <= state_n;
      if (state == IDLE && start) vec <= spike_vec;
      acc           <= (state == IDLE) ? '0 : acc_n;
      d_en          <= weight_rd_en;
      d_idx         <= weight_addr;
      busy          <= state_n != IDLE;
      weight_rd_en  <= state_n == READ;
      weight_addr   <= (state == READ && state_n == READ) ? weight_addr + ADDR_W'(1) : '0;
      current_out   <= state_n == DONE ? sum32 : '0;
      current_valid <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_snn_synapse_accum.sv
// tb_snn_synapse_accum: directed timestep vectors against hand-computed sums with a synchronous weight memory model.
module tb_snn_synapse_accum;
  localparam int N = 4;
  logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic [N-1:0] spike_vec = '0;
  logic busy, weight_rd_en, current_valid;
  logic [1:0] weight_addr;
  logic [31:0] weight_data = '0, current_out;
  logic [31:0] mem [N];
  int errors = 0, checks = 0;

  snn_synapse_accum #(.N_INPUTS(N), .ADDR_W(2), .ACC_W(40)) dut (
    .clk(clk), .resetn(resetn), .start(start), .spike_vec(spike_vec), .busy(busy),
    .weight_rd_en(weight_rd_en), .weight_addr(weight_addr), .weight_data(weight_data),
    .current_out(current_out), .current_valid(current_valid)
  );

  always #5 clk = ~clk;
  // junk on non-read cycles exposes any unqualified accumulation
  always @(posedge clk) weight_data <= weight_rd_en ? mem[weight_addr] : 32'h0BAD_0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // called at a negedge; start is presented in this cycle (T)
  task automatic run_ts(input logic [N-1:0] v, input logic [31:0] exp, input bit ign);
    start = 1'b1;
    spike_vec = v;
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      start = ign && (k == 2 || k == 3);
      if (start) spike_vec = '1;
      check("rd_en", weight_rd_en, k <= N);
      if (k <= N) check("addr", weight_addr, k - 1);
      check("busy", busy, k <= N + 2);
      check("valid", current_valid, k == N + 2);
      check("out", current_out, k == N + 2 ? exp : 32'h0);
    end
  endtask

  initial begin
    mem = '{32'h0001_0000, 32'h0002_0000, 32'hFFFF_8000, 32'h0000_4000};
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rd_en", weight_rd_en, 0);
    check("rst_addr", weight_addr, 0);
    check("rst_out", current_out, 0);
    check("rst_valid", current_valid, 0);
    resetn = 1'b1;
    @(negedge clk);
    run_ts(4'b0111, 32'h0002_8000, 0);
    @(negedge clk);
    run_ts(4'b1011, 32'h0003_4000, 0);
    @(negedge clk);
    run_ts(4'b0100, 32'hFFFF_8000, 0);
    @(negedge clk);
    run_ts(4'b0000, 32'h0000_0000, 0);
    @(negedge clk);
    run_ts(4'b0101, 32'h0000_8000, 1);
    run_ts(4'b0001, 32'h0001_0000, 0);
    run_ts(4'b1000, 32'h0000_4000, 0);
    @(negedge clk);
    start = 1'b1;
    spike_vec = '1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rd_en", weight_rd_en, 0);
    check("mid_rst_addr", weight_addr, 0);
    check("mid_rst_out", current_out, 0);
    check("mid_rst_valid", current_valid, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (N + 4) begin
      @(negedge clk);
      check("post_rst_valid", current_valid, 0);
      check("post_rst_busy", busy, 0);
    end
    run_ts(4'b0011, 32'h0003_0000, 0);
    mem = '{32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000};
    @(negedge clk);
`ifdef SYN_SATURATE_EN
    run_ts(4'b1111, 32'h7FFF_FFFF, 0);
`else
    run_ts(4'b1111, 32'hFFFC_0000, 0);
`endif
    mem = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    @(negedge clk);
`ifdef SYN_SATURATE_EN
    run_ts(4'b1111, 32'h8000_0000, 0);
`else
    run_ts(4'b1111, 32'h0000_0000, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
